// File: rtl/iob_sim_trap_monitor.sv
// Simulation-harness trap monitor: latches trap edges, runs an inactivity watchdog and
// raises finish_o after a drain delay. Status and control sit on an IOb-native CSR port.
module iob_sim_trap_monitor #(
    parameter int unsigned N_TRAP       = 2,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DRAIN_CYCLES = 10,
    parameter int unsigned TIMEOUT_RST  = 0,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 2
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,
    input  logic [N_TRAP-1:0]   trap_i,
    input  logic [N_TRAP-1:0]   activity_i,
    input  logic                iob_avalid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic [DATA_W-1:0]   iob_rdata_o,
    output logic                iob_rvalid_o,
    output logic                iob_ready_o,
    output logic [N_TRAP-1:0]   trap_seen_o,
    output logic                finish_o
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned DRN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int unsigned CLR_B  = (DATA_W > 31) ? 31 : DATA_W - 1;

    typedef enum logic [1:0] {StArmed, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [N_TRAP-1:0]  trap_q, trap_rise, trap_seen_q, mask_q;
    logic [CNT_W-1:0]   cyc_q, tstamp_q, timeout_q, wdog_q;
    logic [DRN_W-1:0]   drain_q;
    logic [3:0]         first_q, first_idx;
    logic               cause_q;
    logic [DATA_W-1:0]  rdata_q, rdata_d, tmo_ext, tmo_wr;
    logic               rvalid_q;
    logic               wr, rd, wr_timeout, wr_ctrl, clear, wr_mask;
    logic               any_rise, any_act, wdog_hit, trigger, st_drain, st_done;

    assign wr         = iob_avalid_i & (|iob_wstrb_i);
    assign rd         = iob_avalid_i & ~(|iob_wstrb_i);
    assign wr_timeout = wr && (iob_addr_i == ADDR_W'(2));
    assign wr_ctrl    = wr && (iob_addr_i == ADDR_W'(3));
    assign clear      = wr_ctrl & iob_wdata_i[CLR_B];
    assign wr_mask    = wr_ctrl & ~iob_wdata_i[CLR_B];

    assign trap_rise = trap_i & ~trap_q & mask_q;
    assign any_rise  = |trap_rise;
    assign any_act   = any_rise | (|activity_i);
    assign wdog_hit  = (timeout_q != '0) && (wdog_q == timeout_q - CNT_W'(1)) && !any_act;
    assign trigger   = (state_q == StArmed) && (any_rise || wdog_hit);

    always_comb begin
        first_idx = '0;
        for (int i = N_TRAP - 1; i >= 0; i--) begin
            if (trap_rise[i]) first_idx = 4'(i);
        end
    end

    // Byte-strobe merge so partial TIMEOUT writes keep the untouched bytes.
    always_comb begin
        tmo_ext = DATA_W'(timeout_q);
        tmo_wr  = tmo_ext;
        for (int b = 0; b < STRB_W; b++) begin
            if (iob_wstrb_i[b]) tmo_wr[b*8 +: 8] = iob_wdata_i[b*8 +: 8];
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= StArmed;
        end else if (cke_i) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StArmed: begin
                if (trigger) state_d = (DRAIN_CYCLES == 0) ? StDone : StDrain;
            end
            StDrain: begin
                if (drain_q == DRN_W'(DRAIN_CYCLES - 1)) state_d = StDone;
            end
            StDone:  state_d = StDone;
            default: state_d = StArmed;
        endcase
        if (clear) state_d = StArmed;
    end

    always_comb begin
        st_drain = (state_q == StDrain);
        st_done  = (state_q == StDone);
        finish_o = st_done;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            trap_q      <= '0;
            trap_seen_q <= '0;
            mask_q      <= '1;
            cyc_q       <= '0;
            tstamp_q    <= '0;
            timeout_q   <= CNT_W'(TIMEOUT_RST);
            wdog_q      <= '0;
            drain_q     <= '0;
            first_q     <= '0;
            cause_q     <= 1'b0;
        end else if (cke_i) begin
            // trap_q always follows trap_i, so a rise coincident with CLEAR is consumed.
            trap_q <= trap_i;
            cyc_q  <= cyc_q + CNT_W'(1);
            if (clear) begin
                trap_seen_q <= '0;
                tstamp_q    <= '0;
                wdog_q      <= '0;
                drain_q     <= '0;
                first_q     <= '0;
                cause_q     <= 1'b0;
            end else begin
                trap_seen_q <= trap_seen_q | trap_rise;
                if (trigger) begin
                    first_q  <= any_rise ? first_idx : 4'd0;
                    cause_q  <= ~any_rise;
                    tstamp_q <= cyc_q;
                end
                if (st_drain && state_d == StDrain) drain_q <= drain_q + DRN_W'(1);
                else drain_q <= '0;
                if (wr_timeout) begin
                    wdog_q <= '0;
                end else if (state_q == StArmed) begin
                    if (any_act) wdog_q <= '0;
                    else if (wdog_q != '1) wdog_q <= wdog_q + CNT_W'(1);
                end
            end
            if (wr_timeout) timeout_q <= tmo_wr[CNT_W-1:0];
            if (wr_mask) mask_q <= iob_wdata_i[N_TRAP-1:0];
        end
    end

    always_comb begin
        rdata_d = '0;
        case (iob_addr_i)
            ADDR_W'(0): begin
                rdata_d[N_TRAP-1:0] = trap_seen_q;
                rdata_d[16]         = st_done;
                rdata_d[17]         = cause_q;
                rdata_d[18]         = st_drain;
                rdata_d[23:20]      = first_q;
            end
            ADDR_W'(1): rdata_d[CNT_W-1:0]  = tstamp_q;
            ADDR_W'(2): rdata_d[CNT_W-1:0]  = timeout_q;
            ADDR_W'(3): rdata_d[N_TRAP-1:0] = mask_q;
            default:    rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (cke_i) begin
            rvalid_q <= rd;
            if (rd) rdata_q <= rdata_d;
        end
    end

    assign iob_rdata_o  = rdata_q;
    assign iob_rvalid_o = rvalid_q;
    assign iob_ready_o  = 1'b1;
    assign trap_seen_o  = trap_seen_q;

endmodule

// File: tb/tb_iob_sim_trap_monitor.sv
// Directed bench for iob_sim_trap_monitor: vector table for trap/mask combinations plus
// hand sequences for drain timing, watchdog, clock-enable freeze and reset abort.
module tb_iob_sim_trap_monitor;

    logic        clk = 1'b0;
    logic        arst_n, cke;
    logic [1:0]  trap, activity;
    logic        avalid;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        rvalid, ready, finish;
    logic [1:0]  trap_seen;

    int nchecks = 0;
    int nerr    = 0;
    int ncyc    = 0;
    int nedge   = 0;

    iob_sim_trap_monitor #(
        .N_TRAP(2), .CNT_W(32), .DRAIN_CYCLES(10), .TIMEOUT_RST(0), .DATA_W(32), .ADDR_W(3)
    ) dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .cke_i        (cke),
        .trap_i       (trap),
        .activity_i   (activity),
        .iob_avalid_i (avalid),
        .iob_addr_i   (addr),
        .iob_wdata_i  (wdata),
        .iob_wstrb_i  (wstrb),
        .iob_rdata_o  (rdata),
        .iob_rvalid_o (rvalid),
        .iob_ready_o  (ready),
        .trap_seen_o  (trap_seen),
        .finish_o     (finish)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mask;
        logic [1:0]  trap;
        logic [31:0] status;
        bit          trig;
    } vec_t;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } rd_t;

    vec_t vecs[8];
    rd_t  rds[5];

    task automatic tick();
        @(posedge clk);
        nedge++;
        if (cke) ncyc++;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        avalid = 1'b1; addr = a; wdata = d; wstrb = 4'hF;
        tick();
        avalid = 1'b0; wstrb = 4'h0; wdata = '0;
    endtask

    task automatic read_check(input logic [2:0] a, input logic [31:0] exp, input string name);
        avalid = 1'b1; addr = a; wstrb = 4'h0;
        tick();
        avalid = 1'b0;
        check({name, " rvalid"}, 32'(rvalid), 32'd1);
        check(name, rdata, exp);
    endtask

    task automatic wait_finish(input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (finish) begin
                at = ncyc;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int at, t0, e, ed, found;
        bit seen;

        vecs[0] = '{2'b11, 2'b10, 32'h0014_0002, 1'b1};
        vecs[1] = '{2'b11, 2'b11, 32'h0004_0003, 1'b1};
        vecs[2] = '{2'b11, 2'b01, 32'h0004_0001, 1'b1};
        vecs[3] = '{2'b01, 2'b10, 32'h0000_0000, 1'b0};
        vecs[4] = '{2'b01, 2'b11, 32'h0004_0001, 1'b1};
        vecs[5] = '{2'b10, 2'b01, 32'h0000_0000, 1'b0};
        vecs[6] = '{2'b10, 2'b10, 32'h0014_0002, 1'b1};
        vecs[7] = '{2'b00, 2'b11, 32'h0000_0000, 1'b0};

        rds[0] = '{3'd0, 32'h0};
        rds[1] = '{3'd1, 32'h0};
        rds[2] = '{3'd2, 32'h0};
        rds[3] = '{3'd5, 32'h0};
        rds[4] = '{3'd3, 32'h3};

        arst_n = 1'b0; cke = 1'b1; trap = '0; activity = '0;
        avalid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        repeat (3) tick();
        check("rst finish", 32'(finish), 0);
        check("rst trap_seen", 32'(trap_seen), 0);
        check("rst rvalid", 32'(rvalid), 0);
        check("rst rdata", rdata, 0);
        check("ready", 32'(ready), 1);
        arst_n = 1'b1; ncyc = 0;

        read_check(3'd0, 32'h0, "rst STATUS");
        read_check(3'd2, 32'h0, "rst TIMEOUT");
        read_check(3'd3, 32'h3, "rst MASK");
        read_check(3'd1, 32'h0, "rst TSTAMP");

        // Single trap at CYC=100 with a 10-cycle drain.
        while (ncyc < 100) tick();
        trap = 2'b10;
        tick();
        read_check(3'd0, 32'h0014_0002, "t1 STATUS drain");
        check("t1 finish early", 32'(finish), 0);
        wait_finish(50, at);
        check("t1 finish cycle", 32'(at), 32'd111);
        read_check(3'd0, 32'h0011_0002, "t1 STATUS done");
        read_check(3'd1, 32'd100, "t1 TSTAMP");
        check("t1 trap_seen", 32'(trap_seen), 32'h2);

        // CLEAR from DONE with trap still held, then CLEAR coincident with a new rise.
        csr_write(3'd3, 32'h8000_0000);
        check("t2 finish after clear", 32'(finish), 0);
        read_check(3'd0, 32'h0, "t2 STATUS after clear");
        trap = 2'b11;
        csr_write(3'd3, 32'h8000_0000);
        repeat (3) tick();
        read_check(3'd0, 32'h0, "t2 STATUS clear+rise");
        check("t2 trap_seen clear+rise", 32'(trap_seen), 0);
        check("t2 finish clear+rise", 32'(finish), 0);

        for (int i = 0; i < 8; i++) begin
            trap = 2'b00;
            csr_write(3'd3, {30'd0, vecs[i].mask});
            csr_write(3'd3, 32'h8000_0000);
            tick();
            t0 = ncyc;
            trap = vecs[i].trap;
            tick();
            read_check(3'd0, vecs[i].status, $sformatf("vec%0d STATUS", i));
            read_check(3'd1, vecs[i].trig ? 32'(t0) : 32'h0, $sformatf("vec%0d TSTAMP", i));
            check($sformatf("vec%0d finish", i), 32'(finish), 0);
        end
        trap = 2'b00;
        csr_write(3'd3, 32'h3);
        csr_write(3'd3, 32'h8000_0000);

        // Watchdog expiry 50 cycles after the TIMEOUT write.
        csr_write(3'd2, 32'd50);
        e = ncyc;
        found = -1;
        avalid = 1'b1; addr = 3'd0; wstrb = 4'h0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rdata[18]) begin
                found = ncyc;
                break;
            end
        end
        avalid = 1'b0;
        check("t3 drain seen cycle", 32'(found), 32'(e + 51));
        read_check(3'd0, 32'h0006_0000, "t3 STATUS timeout");
        wait_finish(30, at);
        check("t3 finish cycle", 32'(at), 32'(e + 60));

        csr_write(3'd3, 32'h8000_0000);
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            activity = (i % 40 != 0) ? 2'b00 : (((i / 40) % 2) != 0 ? 2'b10 : 2'b01);
            tick();
            if (finish) seen = 1'b1;
        end
        activity = 2'b00;
        check("t3 no finish with activity", 32'(seen), 0);
        read_check(3'd0, 32'h0, "t3 STATUS with activity");
        csr_write(3'd2, 32'd0);

        // Clock-enable freeze during DRAIN.
        csr_write(3'd3, 32'h8000_0000);
        tick();
        t0 = ncyc;
        trap = 2'b01;
        tick();
        ed = nedge;
        repeat (3) tick();
        cke = 1'b0;
        seen = 1'b0;
        avalid = 1'b1; addr = 3'd1; wstrb = 4'h0;
        tick();
        avalid = 1'b0;
        check("t5 rvalid frozen", 32'(rvalid), 0);
        repeat (19) begin
            tick();
            if (finish) seen = 1'b1;
        end
        cke = 1'b1;
        check("t5 finish during freeze", 32'(seen), 0);
        wait_finish(40, at);
        check("t5 finish enabled cycle", 32'(at), 32'(t0 + 11));
        check("t5 finish wall cycle", 32'(nedge), 32'(ed + 30));
        read_check(3'd1, 32'(t0), "t5 TSTAMP");

        // Reset in the middle of DRAIN.
        csr_write(3'd3, 32'h8000_0000);
        csr_write(3'd2, 32'd123);
        trap = 2'b00;
        tick();
        trap = 2'b01;
        tick();
        repeat (4) tick();
        arst_n = 1'b0;
        trap = 2'b00;
        #2;
        check("t6 finish in reset", 32'(finish), 0);
        check("t6 trap_seen in reset", 32'(trap_seen), 0);
        repeat (2) tick();
        arst_n = 1'b1; ncyc = 0;

        avalid = 1'b1; wstrb = 4'h0;
        for (int j = 0; j < 5; j++) begin
            addr = rds[j].addr;
            tick();
            check($sformatf("b2b%0d rvalid", j), 32'(rvalid), 1);
            check($sformatf("b2b%0d addr%0d", j, rds[j].addr), rdata, rds[j].data);
        end
        avalid = 1'b0;
        tick();
        check("b2b idle rvalid", 32'(rvalid), 0);
        check("b2b rdata held", rdata, 32'h3);
        repeat (20) tick();
        check("t6 no finish after reset", 32'(finish), 0);

        // Trap held high through reset registers as a rise on the first enabled cycle.
        arst_n = 1'b0;
        trap = 2'b01;
        tick();
        arst_n = 1'b1; ncyc = 0;
        tick();
        read_check(3'd0, 32'h0004_0001, "held trap STATUS");
        read_check(3'd1, 32'h0, "held trap TSTAMP");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
